// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_ctrl
// Description : Sequencing FSM for a radix-2 Booth multiplier datapath.
//               Optional macro BOOTH_CTRL_ABORT_EN adds an 'abort' input.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
`ifdef BOOTH_CTRL_ABORT_EN
    input  logic abort,
`endif
    input  logic q0,
    input  logic qm1,
    output logic clr_a,
    output logic clr_qm1,
    output logic ld_m,
    output logic ld_q,
    output logic ld_a,
    output logic sub,
    output logic shift,
    output logic busy,
    output logic done
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_op_sub;
    logic                 w_op_sub_nxt;
    logic                 w_abort;

`ifdef BOOTH_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_sub <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op_sub <= w_op_sub_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_sub_nxt = r_op_sub;
        clr_a        = 1'b0;
        clr_qm1      = 1'b0;
        ld_m         = 1'b0;
        ld_q         = 1'b0;
        ld_a         = 1'b0;
        sub          = 1'b0;
        shift        = 1'b0;
        done         = 1'b0;
        busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start && !w_abort) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                clr_a       = 1'b1;
                clr_qm1     = 1'b1;
                ld_m        = 1'b1;
                ld_q        = 1'b1;
                w_cnt_nxt   = c_CNT_W'(WIDTH);
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                case ({q0, qm1})
                    2'b10: begin
                        w_op_sub_nxt = 1'b1;
                        w_state_nxt  = S_ADD;
                    end
                    2'b01: begin
                        w_op_sub_nxt = 1'b0;
                        w_state_nxt  = S_ADD;
                    end
                    default: w_state_nxt = S_SHIFT;
                endcase
            end
            S_ADD: begin
                ld_a        = 1'b1;
                sub         = r_op_sub;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // cnt is at least 1 here, so the decrement cannot wrap
                shift       = 1'b1;
                w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                w_state_nxt = (r_cnt == c_CNT_W'(1)) ? S_DONE : S_CHECK;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides the next state only; outputs of this cycle stand
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_booth_ctrl
// Description : Directed bench for booth_ctrl with a Booth datapath model and
//               an expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_ctrl;

    localparam int W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
`ifdef BOOTH_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    logic q0, qm1;
    logic clr_a, clr_qm1, ld_m, ld_q, ld_a, sub, shift, busy, done;
    logic [8:0] outs;

    assign outs = {clr_a, clr_qm1, ld_m, ld_q, ld_a, sub, shift, busy, done};

    always #5 clk = ~clk;

    booth_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef BOOTH_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .q0      (q0),
        .qm1     (qm1),
        .clr_a   (clr_a),
        .clr_qm1 (clr_qm1),
        .ld_m    (ld_m),
        .ld_q    (ld_q),
        .ld_a    (ld_a),
        .sub     (sub),
        .shift   (shift),
        .busy    (busy),
        .done    (done)
    );

    // Datapath model: A, Q, Q-1 and M registers
    logic [W-1:0] ra = '0, rq = '0, rm = '0;
    logic         rqm1 = 1'b0;
    logic [W-1:0] mp = '0, mc = '0;

    always @(posedge clk) begin
        if (clr_a)   ra   <= '0;
        if (clr_qm1) rqm1 <= 1'b0;
        if (ld_m)    rm   <= mc;
        if (ld_q)    rq   <= mp;
        if (ld_a)    ra   <= sub ? (ra - rm) : (ra + rm);
        if (shift)   {ra, rq, rqm1} <= {ra[W-1], ra, rq};
    end

    assign q0  = rq[0];
    assign qm1 = rqm1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           start_cyc;
        int           lat;
        int           nadd;
        logic [31:0]  subs;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0, n_pass = 0, n_done = 0, n_exp_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] mpl, input logic [W-1:0] mcd, input int s);
        exp_t e;
        int   p;
        logic prev;
        e.start_cyc = s;
        e.nadd      = 0;
        e.subs      = '0;
        prev        = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (mpl[i] != prev) begin
                e.subs[e.nadd] = mpl[i];
                e.nadd++;
            end
            prev = mpl[i];
        end
        e.lat  = 2 + 2 * W + e.nadd;
        p      = int'($signed(mpl)) * int'($signed(mcd));
        e.prod = p[2*W-1:0];
        return e;
    endfunction

    // Output monitor: tallies control pulses and scores each done
    int          cur_shift = 0, cur_ld = 0;
    logic [31:0] cur_subs = '0;
    exp_t        mon_e;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ld_q) begin
                cur_shift = 0;
                cur_ld    = 0;
                cur_subs  = '0;
            end
            if (ld_a) begin
                cur_subs[cur_ld] = sub;
                cur_ld++;
            end
            if (shift) cur_shift++;
            if (done) begin
                n_done++;
                check("sb_has_entry_at_done", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    check("latency", 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.lat));
                    check("product", 32'({ra, rq}), 32'(mon_e.prod));
                    check("shift_count", 32'(cur_shift), 32'(W));
                    check("ld_a_count", 32'(cur_ld), 32'(mon_e.nadd));
                    check("sub_sequence", cur_subs, mon_e.subs);
                end
            end
        end
    end

    task automatic run_start(input logic [W-1:0] mpl, input logic [W-1:0] mcd);
        mp    = mpl;
        mc    = mcd;
        start = 1'b1;
        sbq.push_back(model(mpl, mcd, cyc + 1));
        n_exp_done++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int k = 0;
        while (!done && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        exp_t e1, e2;
        int   k, s;

        // Reset held with start high
        #1 rst_n = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 32'(outs), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(outs), 32'd0);

        // Zero multiplier
        run_start(5'b00000, 5'b10110);
        wait_done("done_zero_mpl", 40);
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);

        // 01010 x 00011 with a start pulse while busy
        run_start(5'b01010, 5'b00011);
        repeat (4) @(negedge clk);
        check("busy_mid_op", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_01010", 40);
        repeat (3) begin
            @(negedge clk);
            check("start_in_busy_ignored", 32'(busy), 32'd0);
        end

        // Asynchronous reset in the middle of a SHIFT cycle
        run_start(5'b01010, 5'b00011);
        k = 0;
        while (!shift && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("shift_reached", 32'(shift), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(outs), 32'd0);
        sbq.delete();
        n_exp_done--;
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(outs), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(outs), 32'd0);
        end

        // 11111 x 00101
        run_start(5'b11111, 5'b00101);
        wait_done("done_11111", 40);
        @(negedge clk);

        // start held high: back-to-back multiplies
        mp    = 5'b11111;
        mc    = 5'b00101;
        s     = cyc + 1;
        e1    = model(mp, mc, s);
        e2    = model(mp, mc, s + e1.lat + 1);
        sbq.push_back(e1);
        sbq.push_back(e2);
        n_exp_done += 2;
        start = 1'b1;
        @(negedge clk);
        wait_done("done_b2b_first", 40);
        @(negedge clk);
        check("b2b_idle_gap_busy", 32'(busy), 32'd0);
        check("b2b_idle_gap_ldq", 32'(ld_q), 32'd0);
        @(negedge clk);
        check("b2b_reload", 32'(ld_q), 32'd1);
        @(negedge clk);
        wait_done("done_b2b_second", 40);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("b2b_stops", 32'(busy), 32'd0);
        end

`ifdef BOOTH_CTRL_ABORT_EN
        // Abort during the third CHECK
        begin
            int nchk = 0;
            run_start(5'b01010, 5'b00011);
            k = 0;
            while (nchk < 3 && k < 60) begin
                if (busy && !clr_a && !ld_a && !shift && !done) nchk++;
                if (nchk < 3) @(negedge clk);
                k++;
            end
            check("third_check_found", 32'(nchk), 32'd3);
            abort = 1'b1;
            sbq.delete();
            n_exp_done--;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            @(negedge clk);
            check("abort_quiet", 32'(outs), 32'd0);
            run_start(5'b01010, 5'b00011);
            wait_done("done_after_abort", 40);
            @(negedge clk);
        end
`endif

        repeat (3) @(negedge clk);
        check("done_count", 32'(n_done), 32'(n_exp_done));
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. It drives the accumulator (A) and multiplier (Q) shift registers, the Q₋₁ flip-flop, the multiplicand register (M) and the add/subtract unit through a fixed load / check / add / shift schedule. It signals completion with a one-cycle `done` pulse. It takes the current Booth bit pair from the datapath and holds no data.

## Interface
- `WIDTH`, default 5: operand width, which is also the iteration count; legal range 2..32.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `q0` in 1: LSB of Q register from the datapath.
- `qm1` in 1: Q₋₁ flip-flop from the datapath.
- `clr_a` out 1: clear accumulator A.
- `clr_qm1` out 1: clear Q₋₁.
- `ld_m` out 1: load multiplicand register.
- `ld_q` out 1: load multiplier into Q.
- `ld_a` out 1: load adder/subtractor result into A.
- `sub` out 1: adder performs A−M when 1, A+M when 0; meaningful only while `ld_a`=1.
- `shift` out 1: arithmetic right shift of {A,Q,Q₋₁} this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States are IDLE, LOAD, CHECK, ADD, SHIFT and DONE. The state register and an iteration counter `cnt` (width $clog2(WIDTH+1)) are the only storage, plus a registered `op_sub` bit.
- All outputs are Moore-decoded from the state (plus `op_sub` for `sub`). Outputs are 0 in any state where they are not listed below.
- IDLE: if `start`=1, go to LOAD; otherwise stay.
- LOAD: `clr_a`=`clr_qm1`=`ld_m`=`ld_q`=1. Set `cnt`←WIDTH and go to CHECK.
- CHECK: no outputs asserted. Decode {q0,qm1}:
  - 10: `op_sub`←1, go to ADD.
  - 01: `op_sub`←0, go to ADD.
  - 00 or 11: go to SHIFT.
- ADD: `ld_a`=1 and `sub`=`op_sub`. Go to SHIFT.
- SHIFT: `shift`=1 and `cnt`←`cnt`−1. If `cnt`==1, go to DONE; otherwise go to CHECK.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. The product is valid in {A,Q} from this cycle onward until the next LOAD.
- `start` asserted while `busy`=1 is ignored. It is not queued.
- The counter never wraps: it is only decremented in SHIFT, where `cnt`≥1 is guaranteed.
- Unreachable state encodings go to IDLE on the next edge.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state becomes IDLE and `cnt`=0, `op_sub`=0;
  - all outputs are 0, including `busy` and `done`.
- Reset asserted mid-operation aborts immediately. No `done` pulse is produced, and datapath contents are undefined.
- Release of `rst_n` is synchronized externally. The first active edge after release may sample `start`.
- Sequence: `start` is sampled at edge 0. LOAD occupies cycle 1, and `busy` rises in cycle 1.
- Each iteration takes 2 cycles (CHECK, SHIFT) or 3 cycles (CHECK, ADD, SHIFT).
- Latency from the `start` edge to the `done` cycle is 2 + 2·WIDTH + N_add cycles, where N_add is the number of 01/10 pairs. For WIDTH=5 the range is 12..17.
- In DONE, `done`=1 and `busy`=1. In the following cycle, `busy`=0 and a new `start` is accepted. Back-to-back throughput is therefore one multiply per latency+1 cycles.
- `q0` and `qm1` are sampled only at the end of CHECK. The datapath must present post-shift values by then, which holds because its registers update on the SHIFT edge.

## Configuration
- `BOOTH_CTRL_ABORT_EN` defined:
  - adds input port `abort` (1 bit);
  - `abort`=1 in any non-IDLE state sends the FSM to IDLE at the next edge, sets `cnt`←0 and produces no `done`;
  - in IDLE, `abort` has priority over `start`;
  - control outputs in the abort cycle follow the current state normally.
- `BOOTH_CTRL_ABORT_EN` undefined: no `abort` port exists, and only `rst_n` can terminate an operation.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1, then drop `rst_n` asynchronously mid-SHIFT. All outputs must be 0 immediately, the state must be IDLE, and no `done` may follow.
- Multiplier 00000 (WIDTH=5, datapath model attached): `start` pulse must give 5 `shift` pulses, 0 `ld_a`, and `done` 12 cycles after the start edge.
- Multiplier 01010 × multiplicand 00011: must give `ld_a` pulses with `sub` sequence 1,0,1,0, `done` at 16 cycles, and product {A,Q} = 0x01E (30).
- Multiplier 11111 × multiplicand 00101: must give exactly one `ld_a` with `sub`=1 (first iteration), `done` at 13 cycles, and product = −5 (0x3FB).
- `start` held high continuously: must run back-to-back multiplies, with `done` followed by one IDLE cycle and LOAD in the next. A `start` pulse during `busy` must be ignored.
- With `BOOTH_CTRL_ABORT_EN`: assert `abort` during the third CHECK. The FSM must be in IDLE next cycle with `busy`=0 and no `done`, and the next `start` must complete normally.
